bus_arbnm1s: RTL and testbench

- N:1 bus arbiter. Connects N bus masters (core instruction/data ports, debug, DMA) to one shared slave port, typically the input of the 1:N address-decoding bus multiplexer or a single memory.
- Arbitrates requests round-robin and forwards the winning request.
- Records the winner's ID in an in-order ID FIFO so each response (rvalid/err/rdata) is routed back to the master that issued it.

---
 rtl/bus_arbnm1s_if.sv | 22 ++
 rtl/bus_arbnm1s.sv | 126 ++++++++++++
 tb/tb_bus_arbnm1s.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbnm1s_if.sv
// Simple request/grant bus with one in-order response pulse per accepted request.
// Shared by the arbiter's upstream master ports and its downstream slave port.
interface bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: a request is accepted in the cycle where req & gnt are both high;
    // the requester holds addr/we/be/wdata stable until then. Each accepted request
    // gets exactly one rvalid pulse later (err qualifies it), in acceptance order.
    logic          req;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW/8-1:0] be;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, err, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/bus_arbnm1s.sv
// N:1 bus arbiter with lock-until-grant and an in-order ID FIFO for response routing.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bus_arbnm1s #(
    parameter int N_MASTERS       = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int IDW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    bus_if.slave    master [N_MASTERS],
    bus_if.master   slave
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [N_MASTERS-1:0] m_req;
    logic [31:0]          m_addr  [N_MASTERS];
    logic                 m_we    [N_MASTERS];
    logic [3:0]           m_be    [N_MASTERS];
    logic [31:0]          m_wdata [N_MASTERS];

    logic [IDW-1:0] prio_ptr;
    logic [IDW-1:0] rr_sel;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] lock_id;
    logic           locked;
    logic           found;
    int             idx;

    logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] head;

    logic fwd_req;
    logic push;
    logic pop;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_m
        assign m_req[k]   = master[k].req;
        assign m_addr[k]  = master[k].addr;
        assign m_we[k]    = master[k].we;
        assign m_be[k]    = master[k].be;
        assign m_wdata[k] = master[k].wdata;

        assign master[k].gnt    = push & (sel == IDW'(k));
        assign master[k].rvalid = pop & (head == IDW'(k));
        assign master[k].err    = pop & (head == IDW'(k)) & slave.err;
        assign master[k].rdata  = (pop && head == IDW'(k)) ? slave.rdata : '0;
    end

    // First requester at or above prio_ptr, wrapping around.
    always_comb begin
        rr_sel = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = int'(prio_ptr) + i;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && m_req[idx]) begin
                rr_sel = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign sel     = locked ? lock_id : rr_sel;
    assign fwd_req = m_req[sel] & (|m_req) & (count < CW'(MAX_OUTSTANDING));
    assign push    = fwd_req & slave.gnt;
    assign pop     = slave.rvalid & (count != '0);
    assign head    = id_mem[rd_ptr];

    assign slave.req   = fwd_req;
    assign slave.addr  = m_addr[sel];
    assign slave.we    = m_we[sel];
    assign slave.be    = m_be[sel];
    assign slave.wdata = m_wdata[sel];

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign prio_ptr = '0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_ptr <= '0;
        end else if (push) begin
            prio_ptr <= (sel == IDW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    // A stalled request pins the selection so the forwarded fields cannot change under it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (push) begin
            locked  <= 1'b0;
        end else if (fwd_req) begin
            locked  <= 1'b1;
            lock_id <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) id_mem[i] <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= sel;
                wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbnm1s.sv
// Directed bench for bus_arbnm1s (N=2, depth 2): grants are checked against the
// expected winner, whose ID is queued and later matched to the routed response.
module tb_bus_arbnm1s;
    localparam int IDW = 1;
`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic [31:0] A0 = 32'h000A_0000;
    localparam logic [31:0] A1 = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [IDW-1:0] exp_q [$];

    bus_if m_if [2] ();
    bus_if s_if ();

    bus_arbnm1s #(.N_MASTERS(2), .MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .master (m_if),
        .slave  (s_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r0, input logic r1, input logic sg,
                        input logic rv, input logic se, input logic [31:0] rd);
        @(negedge clk);
        m_if[0].req = r0;
        m_if[1].req = r1;
        s_if.gnt    = sg;
        s_if.rvalid = rv;
        s_if.err    = se;
        s_if.rdata  = rd;
        #1;
    endtask

    task automatic exp_grant(input string tag, input int id, input logic sreq, input logic [31:0] addr);
        if (id >= 0) exp_q.push_back(id[IDW-1:0]);
        chk({tag, ".sreq"}, {31'd0, s_if.req}, {31'd0, sreq});
        chk({tag, ".gnt0"}, {31'd0, m_if[0].gnt}, {31'd0, id == 0});
        chk({tag, ".gnt1"}, {31'd0, m_if[1].gnt}, {31'd0, id == 1});
        if (sreq) chk({tag, ".addr"}, s_if.addr, addr);
    endtask

    task automatic exp_rsp(input string tag, input logic any, input logic [31:0] rd, input logic e);
        int eid;
        eid = -1;
        if (any) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL %s.queue observed=empty expected=entry", tag);
            end else begin
                eid = int'(exp_q.pop_front());
            end
        end
        chk({tag, ".rv0"}, {31'd0, m_if[0].rvalid}, {31'd0, eid == 0});
        chk({tag, ".rv1"}, {31'd0, m_if[1].rvalid}, {31'd0, eid == 1});
        chk({tag, ".err0"}, {31'd0, m_if[0].err}, {31'd0, (eid == 0) & e});
        chk({tag, ".err1"}, {31'd0, m_if[1].err}, {31'd0, (eid == 1) & e});
        chk({tag, ".rd0"}, m_if[0].rdata, (eid == 0) ? rd : 32'd0);
        chk({tag, ".rd1"}, m_if[1].rdata, (eid == 1) ? rd : 32'd0);
    endtask

    initial begin
        m_if[0].req = 1'b0; m_if[0].addr = A0; m_if[0].we = 1'b0; m_if[0].be = 4'hF; m_if[0].wdata = 32'h1111_0000;
        m_if[1].req = 1'b0; m_if[1].addr = A1; m_if[1].we = 1'b1; m_if[1].be = 4'h3; m_if[1].wdata = 32'h2222_0000;
        s_if.gnt = 1'b0; s_if.rvalid = 1'b0; s_if.err = 1'b0; s_if.rdata = 32'd0;

        // Reset state, with a stray rvalid that must not reach anyone.
        #2;
        s_if.rvalid = 1'b1; s_if.rdata = 32'hFFFF_FFFF;
        #1;
        exp_grant("rst", -1, 1'b0, 32'd0);
        exp_rsp("rst", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single master, zero-latency grant and response.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t1.req", 1, 1'b1, A1);
        chk("t1.we", {31'd0, s_if.we}, 32'd1);
        chk("t1.wdata", s_if.wdata, 32'h2222_0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        exp_rsp("t1.rsp", 1'b1, 32'hDEAD_BEEF, 1'b0);

        // 2: both request every cycle, pushes overlap pops at count 1.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, i > 0, 1'b0, 32'h100 + i);
            if (i > 0) exp_rsp("t2.rsp", 1'b1, 32'h100 + i, 1'b0);
            exp_grant("t2.gnt", FIXED ? 0 : (i % 2), 1'b1, (FIXED || i % 2 == 0) ? A0 : A1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
        exp_rsp("t2.drain", 1'b1, 32'h200, 1'b0);

        // 3: master 1 stalls and stays locked while master 0 joins.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        exp_grant("t3.stall0", -1, 1'b1, A1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            exp_grant("t3.stall", -1, 1'b1, A1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t3.gnt1", 1, 1'b1, A1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t3.gnt0", 0, 1'b1, A0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
        exp_rsp("t3.rsp1", 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22);
        exp_rsp("t3.rsp0", 1'b1, 32'h22, 1'b0);

        // 4: fill the FIFO, full blocks even with a same-cycle pop.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t4.gnt0", 0, 1'b1, A0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t4.gnt1", 1, 1'b1, A1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t4.full", -1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0BAD);
        exp_rsp("t4.err", 1'b1, 32'h0BAD, 1'b1);
        exp_grant("t4.nobypass", -1, 1'b0, 32'd0);

        // 5: push and pop together at count 1, then drain and a stray rvalid.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5);
        exp_rsp("t5.rsp", 1'b1, 32'h5, 1'b0);
        exp_grant("t5.resume", 0, 1'b1, A0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77);
        exp_rsp("t5.drain", 1'b1, 32'h77, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h99);
        exp_rsp("t5.stray", 1'b0, 32'd0, 1'b0);

        // 6: one outstanding plus a locked request, then asynchronous reset.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t6.gnt1", 1, 1'b1, A1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        exp_grant("t6.lock", -1, 1'b1, A1);
        @(negedge clk);
        m_if[0].req = 1'b1;
        s_if.rvalid = 1'b1;
        s_if.rdata  = 32'h3333;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_grant("t6.rst", -1, 1'b1, A0);
        exp_rsp("t6.rst", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        exp_grant("t6.after", 0, 1'b1, A0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44);
        exp_rsp("t6.rsp", 1'b1, 32'h44, 1'b0);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL final.queue observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
